// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, 16x16 signed -> 32-bit signed, one step per clock.
// Partial-product add/subtract is delegated to the external 16-bit add/sub stage via as_*.
module booth_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] as_x,
    output logic [15:0] as_y,
    output logic        as_subc,
    input  logic [15:0] as_s,
    input  logic        as_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_a;
    logic [15:0] r_q;
    logic        r_q1;
    logic [15:0] r_m;
    logic [4:0]  r_cnt;
    logic [31:0] r_product;
    logic        r_done;

    logic        w_load;
    logic        w_addsub;
    logic        w_last;
    logic [15:0] w_a_new;
    logic        w_sign;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_addsub    = 1'b0;
        as_subc     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_addsub = r_q[0] ^ r_q1;
                as_subc  = r_q[0] & ~r_q1;
                w_last   = (r_cnt == 5'd15);
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The 16-bit sum can wrap (e.g. M = -32768); sum[15]^ovf recovers the true 17-bit sign.
    assign w_a_new = w_addsub ? as_s : r_a;
    assign w_sign  = w_addsub ? (as_s[15] ^ as_ovf) : r_a[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            if (w_load) begin
                r_m   <= a;
                r_q   <= b;
                r_a   <= '0;
                r_q1  <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_a   <= {w_sign, w_a_new[15:1]};
                r_q   <= {w_a_new[0], r_q[15:1]};
                r_q1  <= r_q[0];
                r_cnt <= r_cnt + 5'd1;
                if (w_last) begin
                    r_product <= {w_sign, w_a_new, r_q[15:1]};
                end
            end
        end
    end

    assign busy    = (r_state == ST_RUN);
    assign done    = r_done;
    assign product = r_product;
    assign as_x    = r_a;
    assign as_y    = r_m;

endmodule
